// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: decodes a 64-byte peripheral window (LED, switches,
// timer, status/control) and passes every other access straight through to dmem.
module mmio_bridge #(
   parameter int          LED_W   = 8,
   parameter int          SW_W    = 8,
   parameter int          TIMER_W = 32,
   parameter logic [31:0] IO_BASE = 32'h0000_1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              we,
   output logic [31:0]       rdata,
   output logic              ram_we,
   input  logic [31:0]       ram_rdata,
   input  logic [SW_W-1:0]   sw_in,
   output logic [LED_W-1:0]  led,
   output logic              irq
);

   localparam logic [3:0] OFF_LED    = 4'd0;
   localparam logic [3:0] OFF_SW     = 4'd1;
   localparam logic [3:0] OFF_CNT    = 4'd2;
   localparam logic [3:0] OFF_CMP    = 4'd3;
   localparam logic [3:0] OFF_STATUS = 4'd4;
   localparam logic [3:0] OFF_CTRL   = 4'd5;

   logic               io_sel;
   logic [3:0]         word;
   logic               io_wr;
   logic               wr_led, wr_cnt, wr_cmp, wr_status, wr_ctrl;

   logic [LED_W-1:0]   led_reg;
   logic [SW_W-1:0]    sw_s1, sw_s2, sw_prev;
   logic [TIMER_W-1:0] cnt, cnt_next, cmp;
   logic               st_match, st_swchg;
   logic [3:0]         ctrl;
   logic               match_hit, swchg_hit;
   logic [31:0]        reg_rd;
   logic               unused_bits;

   assign io_sel = (addr[31:6] == IO_BASE[31:6]);
   assign word   = addr[5:2];
   assign io_wr  = we & io_sel;
   assign ram_we = we & ~io_sel;

   assign wr_led    = io_wr && (word == OFF_LED);
   assign wr_cnt    = io_wr && (word == OFF_CNT);
   assign wr_cmp    = io_wr && (word == OFF_CMP);
   assign wr_status = io_wr && (word == OFF_STATUS);
   assign wr_ctrl   = io_wr && (word == OFF_CTRL);

   // Byte lane bits and upper write-data bits beyond register widths are don't-care.
   assign unused_bits = ^{addr[1:0], wdata};

   assign match_hit = ctrl[0] && (cnt == cmp);
   assign swchg_hit = (sw_s2 != sw_prev);

   // Software load of CNT overrides both increment and auto-reload.
   always_comb begin
      cnt_next = cnt;
      if (ctrl[0]) begin
         if (ctrl[1] && match_hit) cnt_next = '0;
         else                      cnt_next = cnt + TIMER_W'(1);
      end
      if (wr_cnt) cnt_next = wdata[TIMER_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_reg <= '0;
         cnt     <= '0;
         cmp     <= '1;
         ctrl    <= '0;
      end else begin
         if (wr_led)  led_reg <= wdata[LED_W-1:0];
         if (wr_cmp)  cmp     <= wdata[TIMER_W-1:0];
         if (wr_ctrl) ctrl    <= wdata[3:0];
         cnt <= cnt_next;
      end
   end

   // Two-flop synchroniser followed by the previous-value register for change detect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_s1   <= '0;
         sw_s2   <= '0;
         sw_prev <= '0;
      end else begin
         sw_s1   <= sw_in;
         sw_s2   <= sw_s1;
         sw_prev <= sw_s2;
      end
   end

   // Hardware set wins over a simultaneous write-one-to-clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_match <= 1'b0;
         st_swchg <= 1'b0;
      end else begin
         st_match <= match_hit | (st_match & ~(wr_status & wdata[0]));
         st_swchg <= swchg_hit | (st_swchg & ~(wr_status & wdata[1]));
      end
   end

   always_comb begin
      reg_rd = '0;
      unique case (word)
         OFF_LED:    reg_rd = 32'(led_reg);
         OFF_SW:     reg_rd = 32'(sw_s2);
         OFF_CNT:    reg_rd = 32'(cnt);
         OFF_CMP:    reg_rd = 32'(cmp);
         OFF_STATUS: reg_rd = {30'd0, st_swchg, st_match};
         OFF_CTRL:   reg_rd = {28'd0, ctrl};
         default:    reg_rd = '0;
      endcase
   end

   assign rdata = io_sel ? reg_rd : ram_rdata;
   assign led   = led_reg;
   assign irq   = (st_match & ctrl[2]) | (st_swchg & ctrl[3]);

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomised bench for mmio_bridge: a register-map model predicts rdata, ram_we,
// led and irq every cycle; directed sequences pin the model with literal values.
module tb_mmio_bridge;
   localparam int          LED_W   = 8;
   localparam int          SW_W    = 8;
   localparam int          TIMER_W = 32;
   localparam logic [31:0] IO_BASE = 32'h0000_1000;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       addr, wdata, rdata, ram_rdata;
   logic              we, ram_we, irq;
   logic [SW_W-1:0]   sw_in;
   logic [LED_W-1:0]  led;

   int checks = 0;
   int failures = 0;

   mmio_bridge #(.LED_W(LED_W), .SW_W(SW_W), .TIMER_W(TIMER_W), .IO_BASE(IO_BASE)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
      .ram_we(ram_we), .ram_rdata(ram_rdata), .sw_in(sw_in), .led(led), .irq(irq)
   );

   always #10 clk = ~clk;

   // Model state
   logic [LED_W-1:0]   m_led;
   logic [SW_W-1:0]    m_s1, m_s2, m_prev;
   logic [TIMER_W-1:0] m_cnt, m_cmp, n_cnt;
   logic               m_match, m_swchg, hit, swe, w;
   logic [3:0]         m_ctrl;
   int                 off;

   function automatic bit in_io(logic [31:0] a);
      return a[31:6] == IO_BASE[31:6];
   endfunction

   function automatic logic [31:0] exp_rdata(logic [31:0] a);
      if (!in_io(a)) return ram_rdata;
      case (a[5:2])
         4'd0: return 32'(m_led);
         4'd1: return 32'(m_s2);
         4'd2: return 32'(m_cnt);
         4'd3: return 32'(m_cmp);
         4'd4: return {30'd0, m_swchg, m_match};
         4'd5: return {28'd0, m_ctrl};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_led = '0; m_s1 = '0; m_s2 = '0; m_prev = '0;
         m_cnt = '0; m_cmp = '1; m_match = 0; m_swchg = 0; m_ctrl = '0;
      end else begin
         w   = we && in_io(addr);
         off = int'(addr[5:2]);
         hit = m_ctrl[0] && (m_cnt == m_cmp);
         swe = (m_s2 != m_prev);
         if (hit && m_ctrl[1]) n_cnt = '0;
         else if (m_ctrl[0])   n_cnt = m_cnt + 1;
         else                  n_cnt = m_cnt;
         if (w && off == 2) n_cnt = wdata[TIMER_W-1:0];
         m_match = hit || (m_match && !(w && off == 4 && wdata[0]));
         m_swchg = swe || (m_swchg && !(w && off == 4 && wdata[1]));
         if (w && off == 0) m_led  = wdata[LED_W-1:0];
         if (w && off == 3) m_cmp  = wdata[TIMER_W-1:0];
         if (w && off == 5) m_ctrl = wdata[3:0];
         m_cnt  = n_cnt;
         m_prev = m_s2;
         m_s2   = m_s1;
         m_s1   = sw_in;
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      check("cyc_rdata", rdata, exp_rdata(addr));
      check("cyc_ram_we", 32'(ram_we), 32'(we && !in_io(addr)));
      check("cyc_led", 32'(led), 32'(m_led));
      check("cyc_irq", 32'(irq), 32'((m_match & m_ctrl[2]) | (m_swchg & m_ctrl[3])));
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [5:0] o, input logic [31:0] exp, input string nm);
      addr = IO_BASE + 32'(o); we = 1'b0;
      #1;
      check(nm, rdata, exp);
      tick();
   endtask

   initial begin
      reset = 1'b0; addr = '0; wdata = '0; we = 1'b0; ram_rdata = '0; sw_in = '0;
      tick(); tick();
      reset = 1'b1;
      tick();

      // Reset values
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      rd(6'h00, 32'h0, "rst_LED");
      rd(6'h04, 32'h0, "rst_SW");
      rd(6'h08, 32'h0, "rst_CNT");
      rd(6'h0C, 32'hFFFF_FFFF, "rst_CMP");
      rd(6'h10, 32'h0, "rst_STATUS");
      rd(6'h14, 32'h0, "rst_CTRL");

      // Decode and pass-through
      addr = IO_BASE; wdata = 32'hA5; we = 1'b1; #1;
      check("io_wr_ram_we", 32'(ram_we), 32'd0);
      tick(); we = 1'b0;
      check("led_a5", 32'(led), 32'hA5);
      addr = 32'h20; wdata = 32'hDEAD; we = 1'b1; ram_rdata = 32'h1234_5678; #1;
      check("ram_wr_ram_we", 32'(ram_we), 32'd1);
      check("ram_rd", rdata, 32'h1234_5678);
      tick(); we = 1'b0;
      addr = IO_BASE + 32'h20; wdata = 32'hFFFF_FFFF; we = 1'b1; #1;
      check("hole_ram_we", 32'(ram_we), 32'd0);
      check("hole_rd", rdata, 32'd0);
      tick(); we = 1'b0;
      rd(6'h00, 32'hA5, "led_unchanged");

      // Timer with auto-reload and match interrupt
      wr(IO_BASE + 32'h0C, 32'd5);
      wr(IO_BASE + 32'h14, 32'h7);
      for (int i = 0; i < 8; i++) begin
         addr = IO_BASE + 32'h08; #1;
         check("cnt_seq", rdata, 32'(i <= 5 ? i : i - 6));
         check("match_irq", 32'(irq), 32'(i >= 6));
         tick();
      end
      wr(IO_BASE + 32'h10, 32'h1);
      rd(6'h10, 32'h0, "w1c_clear");
      addr = IO_BASE + 32'h08; #1;
      check("cnt_4", rdata, 32'd4);
      tick();
      #1 check("cnt_5", rdata, 32'd5);
      wr(IO_BASE + 32'h10, 32'h1);
      rd(6'h10, 32'h1, "set_beats_w1c");
      wr(IO_BASE + 32'h14, 32'h0);
      wr(IO_BASE + 32'h10, 32'h3);

      // Switch synchroniser and change detect
      wr(IO_BASE + 32'h14, 32'h8);
      sw_in = 8'h3C; addr = IO_BASE + 32'h04; #1;
      check("sw_t0", rdata, 32'h0);
      tick();
      check("sw_e1", rdata, 32'h0);
      tick();
      check("sw_e2", rdata, 32'h3C);
      check("swchg_irq_e2", 32'(irq), 32'd0);
      tick();
      check("swchg_irq_e3", 32'(irq), 32'd1);
      rd(6'h10, 32'h2, "swchg_status");
      wr(IO_BASE + 32'h10, 32'h2);
      rd(6'h10, 32'h0, "swchg_clear");

      // CNT write beats increment; hold when disabled
      wr(IO_BASE + 32'h0C, 32'hFFFF_FFFF);
      wr(IO_BASE + 32'h14, 32'h1);
      wr(IO_BASE + 32'h08, 32'h100);
      rd(6'h08, 32'h100, "cnt_load");
      rd(6'h08, 32'h101, "cnt_inc");
      wr(IO_BASE + 32'h14, 32'h0);
      rd(6'h08, 32'h103, "cnt_hold1");
      rd(6'h08, 32'h103, "cnt_hold2");

      // Async reset mid-count
      wr(IO_BASE + 32'h0C, 32'h37);
      wr(IO_BASE + 32'h08, 32'h30);
      wr(IO_BASE + 32'h14, 32'h5);
      for (int k = 0; k < 20; k++) begin
         if (irq) break;
         tick();
      end
      check("pre_rst_irq", 32'(irq), 32'd1);
      addr = IO_BASE + 32'h08; #1;
      check("pre_rst_cnt", rdata, 32'h38);
      reset = 1'b0; #1;
      check("async_irq", 32'(irq), 32'd0);
      check("async_cnt", rdata, 32'd0);
      check("async_led", 32'(led), 32'd0);
      addr = IO_BASE + 32'h0C; #1;
      check("async_cmp", rdata, 32'hFFFF_FFFF);
      tick();
      reset = 1'b1;
      tick();

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         int sel, wd;
         sel = $urandom_range(0, 9);
         if (sel < 7) begin
            wd = (sel < 5) ? $urandom_range(0, 5) : $urandom_range(0, 15);
            addr = IO_BASE | (32'(wd) << 2) | 32'($urandom_range(0, 3));
            if (wd == 2 || wd == 3) wdata = $urandom_range(0, 20);
            else                    wdata = $urandom;
         end else begin
            addr = $urandom;
            wdata = $urandom;
         end
         we = ($urandom_range(0, 2) == 0);
         ram_rdata = $urandom;
         if ($urandom_range(0, 7) == 0) sw_in = SW_W'($urandom);
         if ($urandom_range(0, 499) == 0) reset = 1'b0;
         else reset = 1'b1;
         tick();
      end
      reset = 1'b1; we = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
